// File: rtl/tank_pkg.sv
// Shared definitions for the player/enemy tank controllers: facing codes,
// life-cycle state encoding and common widths.
package tank_pkg;

  localparam int DIR_W   = 2;
  localparam int LIVES_W = 3;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'b00,
    ST_DEAD   = 2'b01,
    ST_INVULN = 2'b10,
    ST_OVER   = 2'b11
  } state_t;

endpackage

// File: rtl/tank_ctrl_if.sv
// Bus between the tank controller and the bullet blocks: enemy bullet
// positions in, shot request/acknowledge handshake out.
interface tank_ctrl_if #(
  parameter int N_BUL = 4,
  parameter int POS_W = 5
);
  logic [N_BUL*POS_W-1:0] bul_x;
  logic [N_BUL*POS_W-1:0] bul_y;
  logic [N_BUL-1:0]       bul_vld;
  logic                   shot_req;
  logic                   shot_ack;

  // master is the tank controller, slave is the bullet side
  modport master (
    input  bul_x, bul_y, bul_vld, shot_ack,
    output shot_req
  );

  modport slave (
    output bul_x, bul_y, bul_vld, shot_ack,
    input  shot_req
  );
endinterface

// File: rtl/tank_hit_cmp.sv
// N_BUL-way parallel coordinate compare between live bullets and a tank
// position, reduced to one hit bit. Purely combinational.
module tank_hit_cmp #(
  parameter int N_BUL = 4,
  parameter int POS_W = 5
) (
  input  logic [N_BUL*POS_W-1:0] bul_x,
  input  logic [N_BUL*POS_W-1:0] bul_y,
  input  logic [N_BUL-1:0]       bul_vld,
  input  logic [POS_W-1:0]       tank_x,
  input  logic [POS_W-1:0]       tank_y,
  output logic                   hit
);

  logic [N_BUL-1:0] match;

  for (genvar gi = 0; gi < N_BUL; gi++) begin : g_chan
    assign match[gi] = bul_vld[gi]
                     && (bul_x[gi*POS_W +: POS_W] == tank_x)
                     && (bul_y[gi*POS_W +: POS_W] == tank_y);
  end

  assign hit = |match;

endmodule

// File: rtl/tank_ctrl.sv
// Player tank controller: movement, hit detection, lives/respawn FSM and
// shot handshake. Define TANK_INVULN_EN to add post-respawn invulnerability.
module tank_ctrl
  import tank_pkg::*;
#(
  parameter int GRID_W       = 16,
  parameter int GRID_H       = 20,
  parameter int POS_W        = 5,
  parameter int N_BUL        = 4,
  parameter int LIVES        = 3,
  parameter int SPAWN_X      = 8,
  parameter int SPAWN_Y      = 1,
  parameter int DEAD_TICKS   = 4,
  parameter int INVULN_TICKS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 tank_en,
  input  logic                 bt_w,
  input  logic                 bt_s,
  input  logic                 bt_a,
  input  logic                 bt_d,
  input  logic                 bt_st,
  tank_ctrl_if.master          bus,
  output logic [POS_W-1:0]     tank_x,
  output logic [POS_W-1:0]     tank_y,
  output logic [DIR_W-1:0]     tank_dir,
  output logic                 tank_alive,
  output logic [LIVES_W-1:0]   lives,
  output logic                 game_over
);

  localparam logic [POS_W-1:0]   X_MAX   = POS_W'(GRID_W - 1);
  localparam logic [POS_W-1:0]   Y_MAX   = POS_W'(GRID_H - 1);
  localparam logic [POS_W-1:0]   SPX     = POS_W'(SPAWN_X);
  localparam logic [POS_W-1:0]   SPY     = POS_W'(SPAWN_Y);
  localparam logic [POS_W-1:0]   POS_ONE = POS_W'(1);
  localparam logic [LIVES_W-1:0] LIV_ONE = LIVES_W'(1);

  // One timer serves both DEAD and INVULN, so size it for the longer wait.
  localparam int TMR_MAX = (DEAD_TICKS > INVULN_TICKS) ? DEAD_TICKS : INVULN_TICKS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] DEAD_LAST = TMR_W'(DEAD_TICKS - 1);
`ifdef TANK_INVULN_EN
  localparam logic [TMR_W-1:0] INV_LAST  = TMR_W'(INVULN_TICKS - 1);
`endif

  state_t               state_q, state_d;
  logic [POS_W-1:0]     x_q, x_d;
  logic [POS_W-1:0]     y_q, y_d;
  dir_t                 dir_q, dir_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 shot_req_q, shot_req_d;
  logic                 bt_st_q;
  logic                 alive_q, over_q;

  logic                 hit;
  logic                 move_ok;
  logic                 fire_rise;

  tank_hit_cmp #(
    .N_BUL (N_BUL),
    .POS_W (POS_W)
  ) u_hit (
    .bul_x   (bus.bul_x),
    .bul_y   (bus.bul_y),
    .bul_vld (bus.bul_vld),
    .tank_x  (x_q),
    .tank_y  (y_q),
    .hit     (hit)
  );

  assign fire_rise = bt_st & ~bt_st_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    lives_d    = lives_q;
    tmr_d      = tmr_q;
    shot_req_d = shot_req_q;
    move_ok    = 1'b0;

    unique case (state_q)
      ST_ALIVE: begin
        // a hit in the same cycle as a tick suppresses the move
        if (hit) begin
          lives_d = lives_q - LIV_ONE;
          tmr_d   = '0;
          state_d = (lives_q == LIV_ONE) ? ST_OVER : ST_DEAD;
        end else begin
          move_ok = tick & tank_en;
        end
      end
      ST_DEAD: begin
        if (tick) begin
          if (tmr_q == DEAD_LAST) begin
            tmr_d   = '0;
            x_d     = SPX;
            y_d     = SPY;
            dir_d   = DIR_UP;
`ifdef TANK_INVULN_EN
            state_d = ST_INVULN;
`else
            state_d = ST_ALIVE;
`endif
          end else begin
            tmr_d = tmr_q + TMR_ONE;
          end
        end
      end
      ST_INVULN: begin
`ifdef TANK_INVULN_EN
        move_ok = tick & tank_en;
        if (tick) begin
          if (tmr_q == INV_LAST) begin
            tmr_d   = '0;
            state_d = ST_ALIVE;
          end else begin
            tmr_d = tmr_q + TMR_ONE;
          end
        end
`else
        state_d = ST_ALIVE;
`endif
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
    endcase

    if (move_ok) begin
      if (bt_w) begin
        dir_d = DIR_UP;
        if (y_q != Y_MAX) y_d = y_q + POS_ONE;
      end else if (bt_s) begin
        dir_d = DIR_DOWN;
        if (y_q != '0) y_d = y_q - POS_ONE;
      end else if (bt_a) begin
        dir_d = DIR_LEFT;
        if (x_q != '0) x_d = x_q - POS_ONE;
      end else if (bt_d) begin
        dir_d = DIR_RIGHT;
        if (x_q != X_MAX) x_d = x_q + POS_ONE;
      end
    end

    // Leaving ALIVE withdraws a pending request; edges during a request drop.
    if (state_d != ST_ALIVE) begin
      shot_req_d = 1'b0;
    end else if (shot_req_q) begin
      if (bus.shot_ack) shot_req_d = 1'b0;
    end else if ((state_q == ST_ALIVE) && tank_en && fire_rise) begin
      shot_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ALIVE;
      x_q        <= SPX;
      y_q        <= SPY;
      dir_q      <= DIR_UP;
      lives_q    <= LIVES_W'(LIVES);
      tmr_q      <= '0;
      shot_req_q <= 1'b0;
      bt_st_q    <= 1'b0;
      alive_q    <= 1'b1;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      lives_q    <= lives_d;
      tmr_q      <= tmr_d;
      shot_req_q <= shot_req_d;
      bt_st_q    <= bt_st;
      alive_q    <= (state_d == ST_ALIVE) || (state_d == ST_INVULN);
      over_q     <= (state_d == ST_OVER);
    end
  end

  assign tank_x       = x_q;
  assign tank_y       = y_q;
  assign tank_dir     = dir_q;
  assign tank_alive   = alive_q;
  assign lives        = lives_q;
  assign game_over    = over_q;
  assign bus.shot_req = shot_req_q;

endmodule

// File: tb/tb_tank_ctrl.sv
// Self-checking bench for tank_ctrl: directed scenarios plus randomized play,
// all compared against a cycle-level behavioural model of the game rules.
module tb_tank_ctrl;
  import tank_pkg::*;

  localparam int GRID_W = 16, GRID_H = 20, POS_W = 5, N_BUL = 4, LIVES = 3;
  localparam int SPAWN_X = 8, SPAWN_Y = 1, DEAD_TICKS = 4, INVULN_TICKS = 8;
  localparam int P_ALIVE = 0, P_DEAD = 1, P_INV = 2, P_OVER = 3;
`ifdef TANK_INVULN_EN
  localparam bit HAS_INV = 1'b1;
`else
  localparam bit HAS_INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick = 1'b0, tank_en = 1'b0;
  logic bt_w = 1'b0, bt_s = 1'b0, bt_a = 1'b0, bt_d = 1'b0, bt_st = 1'b0;
  logic [POS_W-1:0]   tank_x, tank_y;
  logic [DIR_W-1:0]   tank_dir;
  logic               tank_alive;
  logic [LIVES_W-1:0] lives;
  logic               game_over;

  tank_ctrl_if #(.N_BUL(N_BUL), .POS_W(POS_W)) bus ();

  tank_ctrl #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .POS_W(POS_W), .N_BUL(N_BUL), .LIVES(LIVES),
    .SPAWN_X(SPAWN_X), .SPAWN_Y(SPAWN_Y), .DEAD_TICKS(DEAD_TICKS), .INVULN_TICKS(INVULN_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .tank_en(tank_en),
    .bt_w(bt_w), .bt_s(bt_s), .bt_a(bt_a), .bt_d(bt_d), .bt_st(bt_st),
    .bus(bus),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
    .tank_alive(tank_alive), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus bullets
  int bx [N_BUL];
  int by [N_BUL];
  bit bv [N_BUL];

  // reference model
  int m_x, m_y, m_dir, m_lives, m_phase, m_left, m_shots;
  bit m_req, m_st_prev;

  int dut_shots = 0;
  bit req_seen = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = SPAWN_X; m_y = SPAWN_Y; m_dir = 0; m_lives = LIVES;
    m_phase = P_ALIVE; m_left = 0; m_req = 1'b0; m_st_prev = 1'b0; m_shots = 0;
  endtask

  task automatic model_move();
    if (bt_w) begin
      m_dir = 0; if (m_y < GRID_H - 1) m_y++;
    end else if (bt_s) begin
      m_dir = 1; if (m_y > 0) m_y--;
    end else if (bt_a) begin
      m_dir = 2; if (m_x > 0) m_x--;
    end else if (bt_d) begin
      m_dir = 3; if (m_x < GRID_W - 1) m_x++;
    end
  endtask

  task automatic model_step();
    bit hit, rise;
    int old_phase;
    hit = 1'b0;
    for (int i = 0; i < N_BUL; i++)
      if (bv[i] && bx[i] == m_x && by[i] == m_y) hit = 1'b1;
    rise = bt_st && !m_st_prev;
    m_st_prev = bt_st;
    old_phase = m_phase;
    case (m_phase)
      P_ALIVE: begin
        if (hit) begin
          m_lives--;
          if (m_lives == 0) m_phase = P_OVER;
          else begin m_phase = P_DEAD; m_left = DEAD_TICKS; end
        end else if (tick && tank_en) model_move();
      end
      P_DEAD: begin
        if (tick) begin
          m_left--;
          if (m_left == 0) begin
            m_x = SPAWN_X; m_y = SPAWN_Y; m_dir = 0;
            if (HAS_INV) begin m_phase = P_INV; m_left = INVULN_TICKS; end
            else m_phase = P_ALIVE;
          end
        end
      end
      P_INV: begin
        if (tick && tank_en) model_move();
        if (tick) begin
          m_left--;
          if (m_left == 0) m_phase = P_ALIVE;
        end
      end
      default: ;
    endcase
    if (m_phase != P_ALIVE) m_req = 1'b0;
    else if (m_req) begin
      if (bus.shot_ack) m_req = 1'b0;
    end else if (old_phase == P_ALIVE && tank_en && rise) begin
      m_req = 1'b1;
      m_shots++;
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N_BUL; i++) begin
      bus.bul_x[i*POS_W +: POS_W] = POS_W'(bx[i]);
      bus.bul_y[i*POS_W +: POS_W] = POS_W'(by[i]);
      bus.bul_vld[i] = bv[i];
    end
  endtask

  task automatic compare_all();
    check_eq("tank_x", int'(tank_x), m_x);
    check_eq("tank_y", int'(tank_y), m_y);
    check_eq("tank_dir", int'(tank_dir), m_dir);
    check_eq("tank_alive", int'(tank_alive), int'(m_phase == P_ALIVE || m_phase == P_INV));
    check_eq("lives", int'(lives), m_lives);
    check_eq("game_over", int'(game_over), int'(m_phase == P_OVER));
    check_eq("shot_req", int'(bus.shot_req), int'(m_req));
  endtask

  task automatic step(input string what);
    drive_bus();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    if (bus.shot_req && !req_seen) dut_shots++;
    req_seen = bus.shot_req;
    $display("[%0t] %s: x=%0d y=%0d dir=%0d lives=%0d alive=%0b over=%0b req=%0b",
             $time, what, tank_x, tank_y, tank_dir, lives, tank_alive, game_over, bus.shot_req);
  endtask

  task automatic clear_inputs();
    tick = 1'b0; tank_en = 1'b0;
    bt_w = 1'b0; bt_s = 1'b0; bt_a = 1'b0; bt_d = 1'b0; bt_st = 1'b0;
    bus.shot_ack = 1'b0;
    for (int i = 0; i < N_BUL; i++) begin bx[i] = 0; by[i] = 0; bv[i] = 1'b0; end
    drive_bus();
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    $display("[%0t] reset asserted", $time);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_seen = 1'b0;
    dut_shots = 0;
  endtask

  task automatic tick_pulse(input string what);
    tick = 1'b1; step(what);
    tick = 1'b0; step("idle");
  endtask

  initial begin
    #1;
    apply_reset();
    tank_en = 1'b1;

    // walk right three ticks from spawn
    bt_d = 1'b1;
    for (int k = 0; k < 3; k++) tick_pulse("move d");
    bt_d = 1'b0;
    check_eq("plan_x11", int'(tank_x), 11);
    check_eq("plan_y1", int'(tank_y), 1);
    check_eq("plan_dir_r", int'(tank_dir), 3);

    // drive into the left wall, then one more press
    bt_a = 1'b1;
    for (int k = 0; k < 12; k++) tick_pulse("move a");
    bt_a = 1'b0;
    check_eq("sat_x0", int'(tank_x), 0);
    check_eq("sat_dir_l", int'(tank_dir), 2);

    // w beats a on the same tick
    bt_w = 1'b1; bt_a = 1'b1;
    tick_pulse("move w+a");
    bt_w = 1'b0; bt_a = 1'b0;
    check_eq("prio_y2", int'(tank_y), 2);
    check_eq("prio_x0", int'(tank_x), 0);
    check_eq("prio_dir_up", int'(tank_dir), 0);

    // shot handshake
    bt_st = 1'b1; step("fire edge");
    check_eq("req_rise", int'(bus.shot_req), 1);
    bt_st = 1'b0; step("fire low");
    bt_st = 1'b1; step("fire edge 2");
    check_eq("req_hold", int'(bus.shot_req), 1);
    bt_st = 1'b0; step("fire low");
    bus.shot_ack = 1'b1; step("ack");
    bus.shot_ack = 1'b0;
    check_eq("req_fall", int'(bus.shot_req), 0);
    bus.shot_ack = 1'b1; step("stray ack");
    bus.shot_ack = 1'b0;
    check_eq("one_shot", dut_shots, 1);

    // hit by bullet 2 at the tank's cell
    bx[2] = int'(tank_x); by[2] = int'(tank_y); bv[2] = 1'b1;
    step("hit");
    bv[2] = 1'b0;
    check_eq("hit_lives2", int'(lives), 2);
    check_eq("hit_dead", int'(tank_alive), 0);
    for (int k = 0; k < DEAD_TICKS; k++) tick_pulse("dead tick");
    check_eq("respawn_x", int'(tank_x), SPAWN_X);
    check_eq("respawn_y", int'(tank_y), SPAWN_Y);

    if (HAS_INV) begin
      bx[1] = SPAWN_X; by[1] = SPAWN_Y; bv[1] = 1'b1;
      for (int k = 0; k < INVULN_TICKS; k++) begin
        tick = 1'b1; step("invuln tick");
        tick = 1'b0;
        if (k == INVULN_TICKS - 1) bv[1] = 1'b0;
        step("idle");
      end
      check_eq("invuln_lives2", int'(lives), 2);
      check_eq("invuln_alive", int'(tank_alive), 1);
    end

    // randomized play, with a reset halfway
    for (int c = 0; c < 800; c++) begin
      if (c == 400) begin
        check_eq("rand_shots_a", dut_shots, m_shots);
        apply_reset();
      end
      tick = ($urandom_range(0, 2) == 0);
      tank_en = ($urandom_range(0, 7) != 0);
      bt_w = ($urandom_range(0, 3) == 0);
      bt_s = ($urandom_range(0, 3) == 0);
      bt_a = ($urandom_range(0, 3) == 0);
      bt_d = ($urandom_range(0, 3) == 0);
      bt_st = ($urandom_range(0, 2) == 0);
      bus.shot_ack = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N_BUL; i++) begin
        bx[i] = $urandom_range(0, GRID_W - 1);
        by[i] = $urandom_range(0, GRID_H - 1);
        bv[i] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 120) == 0) begin
        bx[0] = m_x; by[0] = m_y; bv[0] = 1'b1;
      end
      step("random");
    end
    check_eq("rand_shots_b", dut_shots, m_shots);

    // game over: bullet parked on the spawn cell
    apply_reset();
    tank_en = 1'b1;
    bx[0] = SPAWN_X; by[0] = SPAWN_Y; bv[0] = 1'b1;
    for (int k = 0; k < 300 && !game_over; k++) begin
      tick = k[0];
      step("to game over");
    end
    tick = 1'b0;
    check_eq("go_reached", int'(game_over), 1);
    check_eq("go_lives0", int'(lives), 0);

    bv[0] = 1'b0;
    bt_d = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bt_st = k[0];
      tick_pulse("over input");
    end
    bt_d = 1'b0; bt_st = 1'b0;
    check_eq("over_x_frozen", int'(tank_x), SPAWN_X);
    check_eq("over_no_req", int'(bus.shot_req), 0);
    check_eq("over_sticky", int'(game_over), 1);

    // asynchronous reset away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_lives", int'(lives), LIVES);
    check_eq("arst_over", int'(game_over), 0);
    check_eq("arst_alive", int'(tank_alive), 1);
    $display("[%0t] async reset: lives=%0d over=%0b", $time, lives, game_over);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tank_ctrl.md
# tank_ctrl

Parametrised player-tank controller for the grid tank game. It owns the tank's position, facing and life cycle on a configurable playfield. It detects hits from N enemy bullets and runs a lives/respawn state machine. It issues shot requests to the player-bullet block through a req/ack handshake. It sits between the debounced button front-end and the bullet/render blocks; everything is synchronous to `clk`.

## Interface
- `GRID_W`, 16, playfield columns; x range 0..GRID_W-1
- `GRID_H`, 20, playfield rows; y range 0..GRID_H-1
- `POS_W`, 5, coordinate width; must satisfy 2^POS_W ≥ max(GRID_W, GRID_H)
- `N_BUL`, 4, enemy bullet channels checked for hits
- `LIVES`, 3, lives at reset (1..7)
- `SPAWN_X` / `SPAWN_Y`, 8 / 1, spawn and reset position
- `DEAD_TICKS`, 4, ticks spent in DEAD before respawn
- `INVULN_TICKS`, 8, ticks of post-respawn invulnerability

Ports (reset is asynchronous and active-low, one clock):
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `tick`  in  1  one-cycle game-rate strobe (movement/timer step)
- `tank_en`  in  1  global enable; 0 freezes movement and shooting
- `bt_w`, `bt_s`, `bt_a`, `bt_d`  in  1 each  synchronous debounced direction levels
- `bt_st`  in  1  synchronous debounced fire level
- `bul_x`  in  N_BUL*POS_W  packed enemy bullet x, channel i at [i*POS_W +: POS_W]
- `bul_y`  in  N_BUL*POS_W  packed enemy bullet y
- `bul_vld`  in  N_BUL  per-channel bullet live flag
- `shot_ack`  in  1  bullet block accepted the shot
- `shot_req`  out  1  fire request, held until acked
- `tank_x`, `tank_y`  out  POS_W  current position
- `tank_dir`  out  2  facing: 00 up, 01 down, 10 left, 11 right
- `tank_alive`  out  1  1 in ALIVE/INVULN
- `lives`  out  3  remaining lives
- `game_over`  out  1  sticky until reset

## Operation
- FSM states:
  - ALIVE
  - DEAD
  - INVULN
  - OVER
- Movement applies in ALIVE/INVULN on `tick` with `tank_en`=1.
  - One direction per tick, priority w > s > a > d.
  - w: y+1. s: y-1. a: x-1. d: x+1.
  - `tank_dir` updates on every accepted press, even when the move is blocked at an edge.
  - Position saturates at 0 and at GRID_W-1 / GRID_H-1; no wrap.
- Hit: any i with `bul_vld[i]` and (bul_x_i, bul_y_i) == (tank_x, tank_y), while in ALIVE.
  - On a hit: `lives` decrements.
  - If the result is 0, go to OVER; otherwise go to DEAD.
  - Hits are ignored in DEAD, INVULN and OVER.
- DEAD: counts DEAD_TICKS ticks, then loads SPAWN_X/SPAWN_Y, sets `tank_dir`=00 and moves to INVULN.
- INVULN: counts INVULN_TICKS ticks, then moves to ALIVE.
- OVER: absorbing state with `game_over`=1; all inputs are ignored.
- Fire uses the rising edge of `bt_st`, detected against a registered copy.
  - Accepted only in ALIVE with `tank_en`=1 and `shot_req`=0.
  - Accepted edge sets `shot_req`; it clears on the first edge where `shot_ack`=1.
  - Edges while `shot_req`=1 are dropped, not queued.
  - Leaving ALIVE with a request pending withdraws it: `shot_req` clears.

## Timing
- Reset values: `tank_x`=SPAWN_X, `tank_y`=SPAWN_Y, `tank_dir`=00, `lives`=LIVES, state ALIVE, `shot_req`=0, `game_over`=0. Internal counters and edge register reset to 0.
- Outputs are all registered.
- Move latency: `tick` in cycle n gives the new position in cycle n+1.
- Hit latency: coordinate match in cycle n gives `tank_alive`=0 and the decremented `lives` in cycle n+1.
- Hit and `tick` in the same cycle: the hit wins and no move occurs.
- `shot_req` rises the cycle after the `bt_st` edge.
- `shot_req` falls the cycle after `shot_ack` is sampled high.
- `shot_ack` while `shot_req`=0 is ignored.
- `tank_en` deasserted mid-DEAD/INVULN: timers keep counting, since they are tick-driven and not gated.
- Reset asserted mid-operation returns every output to its reset value asynchronously.

## Configuration
- `TANK_INVULN_EN` defined: INVULN state exists as described.
- Undefined: DEAD goes directly to ALIVE at respawn; the INVULN counter and INVULN_TICKS are unused.

## Structure
- Package `tank_pkg` holds:
  - direction codes DIR_UP/DOWN/LEFT/RIGHT
  - FSM state encoding
  - shared width constants
- Sub-module `tank_hit_cmp`: N_BUL-way parallel compare that reduces to a single `hit` bit. Purely combinational, reused by the enemy-tank controller.

## Test plan
- Reset defaults: reset, then 3 ticks holding `bt_d` -> x=11, y=1, dir=11.
- Edge saturation: from x=0, tick with `bt_a` -> x stays 0, dir=10.
- Priority: `bt_w`+`bt_a` on one tick -> y+1 only, dir=00.
- Shot handshake:
  - `bt_st` edge -> `shot_req`=1 next cycle.
  - Second edge before ack -> no change.
  - `shot_ack` pulse -> `shot_req`=0 next cycle.
  - Exactly one shot is recorded.
- Hit and respawn: bullet 2 placed at tank position.
  - `lives` 3->2 and `tank_alive`=0 next cycle.
  - After 4 ticks, tank at (8,1).
  - With `TANK_INVULN_EN`, a bullet on the tank for the next 8 ticks causes no hit.
- Game over: three hits -> `lives`=0, `game_over`=1.
  - Movement and fire then ignored.
  - `rst_n` low -> `lives`=3, `game_over`=0.
